// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with occupancy count, almost-full /
// almost-empty thresholds and sticky overflow / underflow flags.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   defined   -> first-word fall-through: head word is visible on rdata
//                whenever the FIFO is not empty; ren discards it.
//   undefined -> registered read: rdata loads on the edge accepting a read,
//                and rvalid pulses for the following cycle.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   wen / wdata   write request and word
//   ren           read request (acknowledge in FWFT mode)
//   rdata/rvalid  read word and its valid flag
//   wfull/rempty  count == DEPTH / count == 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         occupancy 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

  if (!((AEMPTY_THRESH >= 0) && (AEMPTY_THRESH < AFULL_THRESH) &&
        (AFULL_THRESH <= DEPTH))) begin : g_bad_thresh
    $error("sync_fifo_param: thresholds must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Pointers carry one extra bit, so their difference is the occupancy
  // 0..DEPTH. It depends only on registers, never on this cycle's requests.
  assign count        = wptr - rptr;
  assign wfull        = (count == DEPTH_C);
  assign rempty       = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign wr_acc = wen & ~wfull;
  assign rd_acc = ren & ~rempty;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
      if (wen & wfull)  overflow  <= 1'b1;
      if (ren & rempty) underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = mem[rptr[ADDR_WIDTH-1:0]];
  assign rvalid = ~rempty;
`else
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[rptr[ADDR_WIDTH-1:0]];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       rvalid, wfull, rempty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_param dut (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue plus sticky flags.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_rvalid = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic w, input logic rd, input logic [7:0] d);
    int  sz;
    bit  full, empty;
    if (r) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
    end else begin
      sz    = q.size();
      full  = (sz == DEPTH);
      empty = (sz == 0);
      m_rvalid = 1'b0;
      if (w && full)  m_ovf = 1'b1;
      if (rd && empty) m_unf = 1'b1;
      if (rd && !empty) begin
        m_rdata  = q.pop_front();
        m_rvalid = 1'b1;
      end
      if (w && !full) q.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    m_rvalid = (q.size() != 0);
    if (q.size() != 0) m_rdata = q[0];
`endif
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    check("count",        32'(count),        32'(sz));
    check("rempty",       32'(rempty),       32'(sz == 0));
    check("wfull",        32'(wfull),        32'(sz == DEPTH));
    check("almost_full",  32'(almost_full),  32'(sz >= AF));
    check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_unf));
    check("rvalid",       32'(rvalid),       32'(m_rvalid));
    if (m_rvalid) check("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst = r; wen = w; ren = rd; wdata = d;
    @(posedge clk);
    #1;
    model_update(r, w, rd, d);
    check_model();
  endtask

  typedef struct {
    logic       r, w, rd;
    logic [7:0] d;
    int         cnt;
    logic       ov, un, rv;
    logic [7:0] rdat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // rst  wen ren wdata  count ovf unf rvalid rdata (registered-read mode)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h77, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 8'h55};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b1, 8'h22};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 8'h33};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00};

    #2;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].d);
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_rempty", i), 32'(rempty), 32'(tbl[i].cnt == 0));
      check($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].un));
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      if (tbl[i].rv) check($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].rdat));
`endif
    end

    // Fill to full, overflow, full-boundary simultaneous access, drain.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 12) check("afull_at13", 32'(almost_full), 32'd0);
      if (i == 13) check("afull_at14", 32'(almost_full), 32'd1);
      if (i == 14) check("wfull_at15", 32'(wfull), 32'd0);
    end
    check("wfull_at16", 32'(wfull), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    check("ovf_17th", 32'(overflow), 32'd1);
    check("count_17th", 32'(count), 32'd16);
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    check("count_full_wr_rd", 32'(count), 32'd15);
`ifndef SYNC_FIFO_FWFT_EN
    check("rdata_first", 32'(rdata), 32'h00);
`endif
    for (int i = 1; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("drain_head", 32'(rdata), 32'(i));
`endif
      step(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_data", 32'(rdata), 32'(i));
      check("drain_rvalid", 32'(rvalid), 32'd1);
`endif
    end
    check("drain_rempty", 32'(rempty), 32'd1);
    check("drain_ovf", 32'(overflow), 32'd1);
    check("drain_unf", 32'(underflow), 32'd0);

    // Wrap-around at steady count 5.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8'hC0 + i));
      check("wrap_count", 32'(count), 32'd5);
    end
    check("wrap_ovf", 32'(overflow), 32'd0);
    check("wrap_unf", 32'(underflow), 32'd0);

    // Reset mid-operation clears contents and sticky flags.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("mid_unf_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    check("mid_count9", 32'(count), 32'd9);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_unf", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h5A);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_rdata", 32'(rdata), 32'h5A);
    check("fwft_rvalid", 32'(rvalid), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("fwft_rempty", 32'(rempty), 32'd1);
`else
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("mid_new_data", 32'(rdata), 32'h5A);
`endif

    // Randomised traffic with phase-dependent bias to reach both extremes.
    for (int i = 0; i < 3000; i++) begin
      int  wp, rp;
      logic r;
      wp = ((i / 250) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      r  = ($urandom_range(0, 399) == 0);
      step(r, ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
